// File: rtl/sym2bin_pkg.sv
// Shared definitions for the symbol-to-bin serializer: FSM state encoding,
// default geometry, prefix length and the bin-index width helper.
// No ports (package only).
package sym2bin_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    SUFFIX = 2'd2
  } s2b_state_e;

  // The bin index walks the unary prefix (0..MAX_UNARY) and, for escapes,
  // the suffix bit positions (SYM_W-1..0); it must cover the larger span.
  function automatic int s2b_idx_w(input int sym_w, input int max_unary);
    int span;
    span = (max_unary + 1 > sym_w) ? max_unary + 1 : sym_w;
    return (span > 1) ? $clog2(span) : 1;
  endfunction

  localparam int S2B_SYM_W      = 4;
  localparam int S2B_MAX_UNARY  = 3;
  localparam int S2B_CNT_W      = 16;
  localparam int S2B_PREFIX_LEN = S2B_MAX_UNARY + 1;
  localparam int S2B_IDX_W      = s2b_idx_w(S2B_SYM_W, S2B_MAX_UNARY);

endpackage

// File: rtl/sym2bin_code_gen.sv
// Combinational bin decode: current bin value/ctx/bypass/last and the
// state/index to move to after a non-final bin transfer. Zero latency, no handshake.
// Ports: i_state/i_sym/i_idx in; o_bin_* and o_nxt_state/o_nxt_idx out.
// Macro SYM2BIN_ESCAPE_EN builds the escape (SUFFIX) decode; without it bypass is 0.
module sym2bin_code_gen
  import sym2bin_pkg::*;
#(
  parameter int SYM_W      = S2B_SYM_W,
  parameter int PREFIX_LEN = S2B_PREFIX_LEN,
  parameter int IDX_W      = S2B_IDX_W
) (
  input  s2b_state_e         i_state,
  input  logic [SYM_W-1:0]   i_sym,
  input  logic [IDX_W-1:0]   i_idx,
  output logic               o_bin_value,
  output logic               o_bin_last,
  output logic               o_bin_bypass,
  output logic [1:0]         o_bin_ctx,
  output s2b_state_e         o_nxt_state,
  output logic [IDX_W-1:0]   o_nxt_idx
);

  always_comb begin
    o_bin_value  = 1'b0;
    o_bin_last   = 1'b0;
    o_bin_bypass = 1'b0;
    o_bin_ctx    = 2'd0;
    o_nxt_state  = i_state;
    o_nxt_idx    = i_idx;
    case (i_state)
      PREFIX: begin
        o_bin_ctx   = 2'(i_idx);
        // For escape symbols every prefix bin is 1, which this compare gives
        // for free because idx never exceeds MAX_UNARY < sym.
        o_bin_value = int'(i_idx) < int'(i_sym);
        o_nxt_idx   = i_idx + IDX_W'(1);
        if (int'(i_sym) < PREFIX_LEN) begin
          o_bin_last = (int'(i_idx) == int'(i_sym));
        end
`ifdef SYM2BIN_ESCAPE_EN
        else if (int'(i_idx) == PREFIX_LEN - 1) begin
          o_nxt_state = SUFFIX;
          o_nxt_idx   = IDX_W'(SYM_W - 1);
        end
`endif
      end
`ifdef SYM2BIN_ESCAPE_EN
      SUFFIX: begin
        o_bin_value  = i_sym[i_idx];
        o_bin_bypass = 1'b1;
        o_bin_last   = (i_idx == '0);
        o_nxt_idx    = i_idx - IDX_W'(1);
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/sym_bin_serializer.sv
// Serializes accepted symbols into truncated-unary bins, one bin per clock.
// Latency: symbol accepted in cycle N -> first bin valid in cycle N+1; back-to-back symbols have no bubble.
// Backpressure: bins hold while bin_valid & !bin_ready; sym_ready is combinational from bin_ready on the last bin.
// Ports: sys_clk, sys_reset (async active-low); sym_in/sym_valid/sym_ready symbol side;
//   bin_value/bin_ctx/bin_bypass/bin_last/bin_valid/bin_ready bin side; sym_count emitted-symbol counter.
// Macro SYM2BIN_ESCAPE_EN: escape coding (prefix "1111" + raw SYM_W-bit suffix); otherwise symbols saturate to MAX_UNARY.
module sym_bin_serializer
  import sym2bin_pkg::*;
#(
  parameter int SYM_W     = S2B_SYM_W,
  parameter int MAX_UNARY = S2B_MAX_UNARY,
  parameter int CNT_W     = S2B_CNT_W
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic             bin_value,
  output logic [1:0]       bin_ctx,
  output logic             bin_bypass,
  output logic             bin_last,
  output logic             bin_valid,
  input  logic             bin_ready,
  output logic [CNT_W-1:0] sym_count
);

  localparam int PREFIX_LEN = MAX_UNARY + 1;
  localparam int IDX_W      = s2b_idx_w(SYM_W, MAX_UNARY);

  s2b_state_e       r_state;
  logic [SYM_W-1:0] r_sym;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_sym_count;

  s2b_state_e       w_nxt_state;
  logic [SYM_W-1:0] w_nxt_sym;
  logic [IDX_W-1:0] w_nxt_idx;
  logic [CNT_W-1:0] w_nxt_count;
  s2b_state_e       w_cg_state;
  logic [IDX_W-1:0] w_cg_idx;
  logic [SYM_W-1:0] w_sym_lat;
  logic             w_bin_xfer;
  logic             w_sym_acc;

  sym2bin_code_gen #(
    .SYM_W      (SYM_W),
    .PREFIX_LEN (PREFIX_LEN),
    .IDX_W      (IDX_W)
  ) u_code_gen (
    .i_state      (r_state),
    .i_sym        (r_sym),
    .i_idx        (r_idx),
    .o_bin_value  (bin_value),
    .o_bin_last   (bin_last),
    .o_bin_bypass (bin_bypass),
    .o_bin_ctx    (bin_ctx),
    .o_nxt_state  (w_cg_state),
    .o_nxt_idx    (w_cg_idx)
  );

  assign bin_valid  = (r_state != IDLE);
  assign w_bin_xfer = bin_valid & bin_ready;
  assign sym_ready  = (r_state == IDLE) | (w_bin_xfer & bin_last);
  assign w_sym_acc  = sym_valid & sym_ready;
  assign sym_count  = r_sym_count;

`ifdef SYM2BIN_ESCAPE_EN
  assign w_sym_lat = sym_in;
`else
  // Without escape coding, large symbols collapse onto the longest unary code.
  assign w_sym_lat = (int'(sym_in) > MAX_UNARY) ? SYM_W'(MAX_UNARY) : sym_in;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_sym   = r_sym;
    w_nxt_idx   = r_idx;
    w_nxt_count = r_sym_count;
    if (w_bin_xfer) begin
      if (bin_last) begin
        w_nxt_state = IDLE;
        w_nxt_count = r_sym_count + CNT_W'(1);
      end else begin
        w_nxt_state = w_cg_state;
        w_nxt_idx   = w_cg_idx;
      end
    end
    // Acceptance only happens in IDLE or on the final bin, so it overrides
    // the return to IDLE and chains the next symbol without a bubble.
    if (w_sym_acc) begin
      w_nxt_state = PREFIX;
      w_nxt_sym   = w_sym_lat;
      w_nxt_idx   = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      r_state     <= IDLE;
      r_sym       <= '0;
      r_idx       <= '0;
      r_sym_count <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_sym       <= w_nxt_sym;
      r_idx       <= w_nxt_idx;
      r_sym_count <= w_nxt_count;
    end
  end

endmodule

// File: tb/tb_sym_bin_serializer.sv
// Scoreboard bench for sym_bin_serializer: accepted symbols expand into expected
// bin strings in a queue; a monitor pops and compares on every bin transfer.
// The counter is built 8 bits wide here so the wrap point is reachable quickly.
module tb_sym_bin_serializer;

  localparam int SYM_W     = 4;
  localparam int MAX_UNARY = 3;
  localparam int CNT_W     = 8;

  typedef struct packed {
    logic       val;
    logic [1:0] ctx;
    logic       byp;
    logic       last;
  } bin_t;

  logic             sys_clk   = 1'b0;
  logic             sys_reset = 1'b1;
  logic [SYM_W-1:0] sym_in    = '0;
  logic             sym_valid = 1'b0;
  logic             bin_ready = 1'b0;
  logic             sym_ready;
  logic             bin_value;
  logic [1:0]       bin_ctx;
  logic             bin_bypass;
  logic             bin_last;
  logic             bin_valid;
  logic [CNT_W-1:0] sym_count;

  sym_bin_serializer #(
    .SYM_W     (SYM_W),
    .MAX_UNARY (MAX_UNARY),
    .CNT_W     (CNT_W)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_reset  (sys_reset),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .bin_value  (bin_value),
    .bin_ctx    (bin_ctx),
    .bin_bypass (bin_bypass),
    .bin_last   (bin_last),
    .bin_valid  (bin_valid),
    .bin_ready  (bin_ready),
    .sym_count  (sym_count)
  );

  always #5 sys_clk = ~sys_clk;

  bin_t             exp_q[$];
  logic [CNT_W-1:0] exp_count = '0;
  int               checks    = 0;
  int               failures  = 0;
  bit               rdy_rand  = 1'b0;
  bit               track     = 1'b0;
  int               cyc       = 0;
  int               first_vld = -1;
  int               last_vld  = -1;
  int               vld_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference code table: the bin string a symbol must produce.
  task automatic push_model(input logic [SYM_W-1:0] s);
    int v;
    v = int'(s);
`ifndef SYM2BIN_ESCAPE_EN
    if (v > MAX_UNARY) v = MAX_UNARY;
`endif
    if (v <= MAX_UNARY) begin
      for (int i = 0; i < v; i++) exp_q.push_back(bin_t'{1'b1, 2'(i), 1'b0, 1'b0});
      exp_q.push_back(bin_t'{1'b0, 2'(v), 1'b0, 1'b1});
    end else begin
      for (int i = 0; i <= MAX_UNARY; i++) exp_q.push_back(bin_t'{1'b1, 2'(i), 1'b0, 1'b0});
      for (int b = SYM_W - 1; b >= 0; b--) exp_q.push_back(bin_t'{s[b], 2'd0, 1'b1, (b == 0)});
    end
  endtask

  // Stimulus side of the scoreboard: record each symbol the DUT is about to accept.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_reset && sym_valid && sym_ready) push_model(sym_in);
    end
  end

  // Monitor: compare every presented bin, stall stability, sym_ready and the counter.
  initial begin
    bin_t cur;
    bin_t prev;
    bin_t e;
    bit   stalled;
    stalled = 1'b0;
    prev    = '0;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (!sys_reset) begin
        exp_q.delete();
        exp_count = '0;
        stalled   = 1'b0;
        continue;
      end
      check("sym_count", 32'(sym_count), 32'(exp_count));
      cur = bin_t'{bin_value, bin_ctx, bin_bypass, bin_last};
      if (stalled) check("stall_hold", {bin_valid, cur}, {1'b1, prev});
      if (bin_valid) begin
        if (track) begin
          if (first_vld < 0) first_vld = cyc;
          last_vld = cyc;
          vld_cnt++;
        end
        if (exp_q.size() == 0) begin
          check("spurious_bin_valid", 32'(bin_valid), 32'(0));
        end else begin
          e = exp_q[0];
          check("bin_val_ctx_byp_last", 32'(cur), 32'(e));
          check("sym_ready_busy", 32'(sym_ready), 32'(bin_ready & e.last));
          if (bin_ready) begin
            void'(exp_q.pop_front());
            if (e.last) exp_count++;
          end
        end
        stalled = !bin_ready;
        prev    = cur;
      end else begin
        check("sym_ready_idle", 32'(sym_ready), 32'(1));
        stalled = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (rdy_rand) bin_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_sym(input logic [SYM_W-1:0] s);
    bit acc;
    acc       = 1'b0;
    sym_valid = 1'b1;
    sym_in    = s;
    for (int n = 0; n < 200 && !acc; n++) begin
      #1;
      acc = sym_ready;
      tick();
    end
    sym_valid = 1'b0;
    sym_in    = SYM_W'($urandom);
    if (!acc) check("sym_accept_timeout", 32'(acc), 32'(1));
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 400 && !idle; n++) begin
      if (exp_q.size() == 0 && !bin_valid) idle = 1'b1;
      else tick();
    end
    if (!idle) check("drain_timeout", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bin_valid"},  32'(bin_valid),  32'(0));
    check({tag, "_sym_ready"},  32'(sym_ready),  32'(1));
    check({tag, "_bin_value"},  32'(bin_value),  32'(0));
    check({tag, "_bin_ctx"},    32'(bin_ctx),    32'(0));
    check({tag, "_bin_bypass"}, 32'(bin_bypass), 32'(0));
    check({tag, "_bin_last"},   32'(bin_last),   32'(0));
    check({tag, "_sym_count"},  32'(sym_count),  32'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pat;
    // Power-on reset.
    #1 sys_reset = 1'b0;
    #2 check_reset_outputs("por");
    repeat (3) tick();
    sys_reset = 1'b1;
    bin_ready = 1'b1;
    tick();

    // Back-to-back unary codes with the coder always ready.
    track = 1'b1; first_vld = -1; last_vld = -1; vld_cnt = 0;
    send_sym(4'd0);
    send_sym(4'd1);
    send_sym(4'd2);
    send_sym(4'd3);
    wait_idle();
    track = 1'b0;
    check("b2b_bin_cycles", 32'(vld_cnt), 32'(10));
    check("b2b_no_bubble", 32'(last_vld - first_vld + 1), 32'(10));
    check("b2b_sym_count", 32'(sym_count), 32'(4));

    // Symbol above the unary range.
    send_sym(4'd9);
    wait_idle();

    // Stall pattern 1,0,0,1,1 on a sym-2 code.
    send_sym(4'd2);
    pat = 5'b11001;
    for (int k = 0; k < 5; k++) begin
      bin_ready = pat[k];
      tick();
    end
    bin_ready = 1'b1;
    wait_idle();

    // Reset while the second bin of sym 3 is on the output.
    send_sym(4'd3);
    tick();
    sys_reset = 1'b0;
    #1 check_reset_outputs("midrst");
    tick();
    tick();
    sys_reset = 1'b1;
    tick();
    send_sym(4'd1);
    wait_idle();
    check("post_rst_sym_count", 32'(sym_count), 32'(1));

    // Random symbols, gaps and coder stalls.
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_sym(SYM_W'($urandom_range(0, (1 << SYM_W) - 1)));
    end
    wait_idle();
    rdy_rand  = 1'b0;
    bin_ready = 1'b1;

    // Counter wrap from all-ones back to zero.
    sys_reset = 1'b0;
    tick();
    sys_reset = 1'b1;
    tick();
    for (int i = 0; i < (1 << CNT_W) - 1; i++) send_sym(4'd0);
    wait_idle();
    check("wrap_at_max", 32'(sym_count), 32'((1 << CNT_W) - 1));
    send_sym(4'd0);
    wait_idle();
    check("wrap_to_zero", 32'(sym_count), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sym_bin_serializer.md
# sym_bin_serializer

Serializes each accepted symbol into its truncated-unary bin string, one bin per clock, for the binary arithmetic coding engine. It sits directly downstream of symbol binarization, between the symbol source and the coder. Each bin is tagged with a context index, or with a bypass flag for raw escape bits. Valid/ready handshakes on both sides let the coder stall the stream.

## Interface
- SYM_W, 4, symbol width in bits; also the escape-suffix length.
- MAX_UNARY, 3, largest symbol coded as pure unary; its code has MAX_UNARY ones followed by a terminating 0.
- CNT_W, 16, width of the symbol counter.
- sys_clk  in  1  system clock, rising edge.
- sys_reset  in  1  asynchronous, active-low reset.
- sym_in  in  SYM_W  input symbol.
- sym_valid  in  1  sym_in is valid.
- sym_ready  out  1  block accepts sym_in this cycle.
- bin_value  out  1  current bin.
- bin_ctx  out  2  bin position within the prefix (0..MAX_UNARY); 0 for bypass bins.
- bin_bypass  out  1  bin is a raw escape-suffix bit.
- bin_last  out  1  final bin of the current symbol.
- bin_valid  out  1  bin outputs are valid.
- bin_ready  in  1  coder consumes the bin.
- sym_count  out  CNT_W  number of fully emitted symbols; wraps.

## Operation
- Codes for sym ≤ MAX_UNARY: sym ones, then a single 0. Examples: 0→"0", 1→"10", 2→"110", 3→"1110".
- Codes for sym > MAX_UNARY (escape): MAX_UNARY+1 ones ("1111"), then all SYM_W bits of sym, MSB first, with bin_bypass=1.
- FSM states:
  - IDLE: sym_ready=1, bin_valid=0. A transfer (sym_valid&sym_ready) latches sym and clears the bin index → PREFIX.
  - PREFIX: bin_value = (idx < sym) within the unary range. bin_ctx = idx. Each bin transfer increments idx.
    - Unary symbol: after the 0 bin → done.
    - Escape symbol: after bin MAX_UNARY (value 1) → SUFFIX, idx=SYM_W-1.
  - SUFFIX: bin_value = sym[idx], bin_bypass=1, bin_ctx=0. Decrement idx per transfer; bin_last when idx=0 → done.
  - done: sym_count increments. If a new symbol is accepted in the same cycle → PREFIX with the new symbol, else → IDLE.
- sym_ready = (state==IDLE) | (bin_valid & bin_ready & bin_last). This is a combinational path from bin_ready, which the coder tolerates.
- Outputs hold stable while bin_valid & !bin_ready; no bin is dropped or duplicated.
- sym_in is ignored when sym_valid=0.

## Timing
- Reset values: sym_ready=1 (IDLE), bin_valid=0, bin_value=0, bin_ctx=0, bin_bypass=0, bin_last=0, sym_count=0, state IDLE.
- Latency: symbol accepted in cycle N → first bin valid in cycle N+1 (registered).
- Throughput with bin_ready held high: one bin per cycle, no bubble between symbols. A unary code takes sym+1 cycles; an escape takes MAX_UNARY+1+SYM_W cycles.
- Reset asserted mid-symbol: the in-flight symbol is discarded, all outputs go to reset values at once, and sym_count is cleared.
- sym_count wraps from 2^CNT_W-1 to 0 silently.

## Configuration
- SYM2BIN_ESCAPE_EN defined: escape coding as described above.
- SYM2BIN_ESCAPE_EN undefined:
  - Symbols > MAX_UNARY are saturated to MAX_UNARY and coded as "1110".
  - SUFFIX state is not built; bin_bypass is tied to 0.

## Structure
- Shared package sym2bin_pkg holds the state enum (IDLE, PREFIX, SUFFIX) and localparams for prefix length (MAX_UNARY+1) and index width.
- One sub-module is natural: sym2bin_code_gen, a combinational bin_value/bin_last/next-state decode from {state, sym, idx}. The top keeps the registers and handshake.

## Test plan
- Send sym 0,1,2,3 back-to-back with bin_ready=1 → bins 0|10|110|1110; bin_last on each 0; no idle cycles; sym_count=4.
- Send sym 9 with SYM2BIN_ESCAPE_EN → bins 1,1,1,1 (ctx 0..3), then bypass bins 1,0,0,1; bin_last on the final bin.
- Send sym 9 without the macro → bins 1110 with bin_bypass=0 throughout.
- Send sym 2 with bin_ready toggling 1,0,0,1,1 → bins 1,1,0 each held stable while stalled; sym_ready=0 until the last transfer.
- Deassert sys_reset on the 2nd bin of sym 3 → next cycle bin_valid=0, sym_ready=1, sym_count=0. After release, sym 1 yields "10".
- Preload sym_count to 0xFFFF with one extra symbol → count reads 0x0000.
